// File: rtl/muldiv_hilo_if.sv
// EX-stage request/response bundle between the pipeline and the mult/div HI/LO unit.
// valid/ready: start is the request and stall is the inverse of ready; a request is taken on the first edge where start=1 and stall=0.
interface muldiv_hilo_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [1:0]  whilo;
  logic [31:0] wdata;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, src_a, src_b, whilo, wdata,
                  input  stall, busy, hi, lo);
  modport slave  (input  start, op, src_a, src_b, whilo, wdata,
                  output stall, busy, hi, lo);
endinterface

// File: rtl/muldiv_hilo.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; stalls the front pipeline while it runs.
// Optional MULDIV_FLUSH_EN adds a flush input that cancels the EX instruction.
module muldiv_hilo #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_ITER   = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
`ifdef MULDIV_FLUSH_EN
  input  logic                 flush,
`endif
  muldiv_hilo_if.slave         bus,
  output logic [1:0]           o_dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  r_state;
  logic        r_busy;
  logic [4:0]  r_cnt;
  logic        r_unsigned;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_flush;
  logic        w_issue;
  logic [31:0] w_abs_src_a;
  logic [31:0] w_b_mag;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_prod;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic        w_q_neg;
  logic        w_r_neg;
  logic [31:0] w_div_lo;
  logic [31:0] w_div_hi;

`ifdef MULDIV_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_issue   = bus.start & ~bus.op[2] & (r_state == ST_IDLE) & ~w_flush;
  assign bus.stall = ~w_flush & (w_issue | (r_state == ST_MUL) | (r_state == ST_DIV));
  assign bus.busy  = r_busy;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign o_dbg_state = r_state;

  // Dividend magnitude is loaded straight into the quotient shifter at issue.
  assign w_abs_src_a = (~bus.op[0] & bus.src_a[31]) ? -bus.src_a : bus.src_a;
  assign w_b_mag     = (~r_unsigned & r_b[31]) ? -r_b : r_b;

  assign w_a64  = r_unsigned ? {32'b0, r_a} : {{32{r_a[31]}}, r_a};
  assign w_b64  = r_unsigned ? {32'b0, r_b} : {{32{r_b[31]}}, r_b};
  assign w_prod = w_a64 * w_b64;

  // rem < divisor always, so a set bit 32 of the difference can only mean borrow.
  assign w_shift  = {r_rem, r_quo[31]};
  assign w_diff   = w_shift - {1'b0, w_b_mag};
  assign w_ge     = ~w_diff[32];
  assign w_rem_nx = w_ge ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_nx = {r_quo[30:0], w_ge};

  assign w_q_neg  = ~r_unsigned & (r_a[31] ^ r_b[31]);
  assign w_r_neg  = ~r_unsigned & r_a[31];
  assign w_div_lo = (r_b == 32'd0) ? 32'hFFFF_FFFF : (w_q_neg ? -w_quo_nx : w_quo_nx);
  assign w_div_hi = (r_b == 32'd0) ? r_a : (w_r_neg ? -w_rem_nx : w_rem_nx);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_cnt      <= 5'd0;
      r_unsigned <= 1'b0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_rem      <= 32'd0;
      r_quo      <= 32'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
    end else if (w_flush) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.whilo[1]) r_hi <= bus.wdata;
          if (bus.whilo[0]) r_lo <= bus.wdata;
          if (w_issue) begin
            r_unsigned <= bus.op[0];
            r_a        <= bus.src_a;
            r_b        <= bus.src_b;
            r_rem      <= 32'd0;
            r_quo      <= w_abs_src_a;
            r_busy     <= 1'b1;
            if (bus.op[1]) begin
              r_state <= ST_DIV;
              r_cnt   <= 5'(DIV_ITER - 1);
            end else begin
              r_state <= ST_MUL;
              r_cnt   <= 5'(MUL_CYCLES - 1);
            end
          end
        end
        ST_MUL: begin
          if (r_cnt == 5'd0) begin
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        ST_DIV: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          if (r_cnt == 5'd0) begin
            r_hi    <= w_div_hi;
            r_lo    <= w_div_lo;
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo: HI/LO results, stall lengths, direct writes, reset and flush.
module tb_muldiv_hilo;
  logic clk;
  logic resetn;
  logic [1:0] dbg_state;
  int n_total;
  int n_bad;

  muldiv_hilo_if bus ();

`ifdef MULDIV_FLUSH_EN
  logic flush;
  muldiv_hilo dut (.clk(clk), .resetn(resetn), .flush(flush), .bus(bus), .o_dbg_state(dbg_state));
`else
  muldiv_hilo dut (.clk(clk), .resetn(resetn), .bus(bus), .o_dbg_state(dbg_state));
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (bus.stall === 1'b1 && n < 200) begin
      n++;
      if (n == 2) check("busy_run", 64'(bus.busy), 64'd1);
      @(negedge clk); #1;
    end
  endtask

  task automatic finish_op(input string tag, input [31:0] exp_hi, input [31:0] exp_lo);
    check({tag, "_done_state"}, 64'(dbg_state), 64'd3);
    check({tag, "_done_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check({tag, "_no_reissue"}, 64'(dbg_state), 64'd0);
    check({tag, "_hold_lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  task automatic run_op(input string tag, input [2:0] op, input [31:0] a, input [31:0] b,
                        input [31:0] exp_hi, input [31:0] exp_lo, input int exp_cyc);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    #1;
    count_stall(n);
    check({tag, "_stall_cyc"}, 64'(n), 64'(exp_cyc));
    finish_op(tag, exp_hi, exp_lo);
  endtask

  initial begin
    int n;
    n_total = 0;
    n_bad   = 0;
    resetn  = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.src_a = 32'd0; bus.src_b = 32'd0;
    bus.whilo = 2'b00; bus.wdata = 32'd0;
`ifdef MULDIV_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // MTHI on an idle unit
    @(negedge clk);
    bus.whilo = 2'b10; bus.wdata = 32'h1234;
    #1;
    check("mthi_stall0", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.whilo = 2'b00;
    #1;
    check("mthi_hi", 64'(bus.hi), 64'h1234);
    check("mthi_lo", 64'(bus.lo), 64'd0);
    check("mthi_stall1", 64'(bus.stall), 64'd0);

    // MTLO and MULT 2x3 in the same cycle
    @(negedge clk);
    bus.whilo = 2'b01; bus.wdata = 32'hAA;
    bus.start = 1'b1; bus.op = 3'b000; bus.src_a = 32'd2; bus.src_b = 32'd3;
    #1;
    check("mtlo_mult_stall", 64'(bus.stall), 64'd1);
    @(negedge clk);
    bus.whilo = 2'b00;
    #1;
    check("mtlo_first_lo", 64'(bus.lo), 64'hAA);
    check("mtlo_first_hi", 64'(bus.hi), 64'h1234);
    count_stall(n);
    check("mtlo_mult_stall_cyc", 64'(n + 1), 64'd3);
    finish_op("mtlo_mult", 32'h0, 32'h6);

    run_op("mult_neg",   3'b000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 3);
    run_op("multu_big",  3'b001, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 3);
    run_op("mult_m1m1",  3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 3);
    run_op("multu_max",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3);
    run_op("div_m7_2",   3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run_op("div_7_m2",   3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);
    run_op("divu_100_7", 3'b011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33);
    run_op("div_ovf",    3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
    run_op("divu_5_0",   3'b011, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 33);
    run_op("div_m8_0",   3'b010, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 33);

    // undefined op code: no stall, MTLO still honoured
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b101; bus.whilo = 2'b01; bus.wdata = 32'h55;
    #1;
    check("noop_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.whilo = 2'b00;
    #1;
    check("noop_state", 64'(dbg_state), 64'd0);
    check("noop_lo", 64'(bus.lo), 64'h55);
    check("noop_hi", 64'(bus.hi), 64'hFFFFFFF8);

`ifdef MULDIV_FLUSH_EN
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    flush = 1'b0; bus.start = 1'b0;
    #1;
    check("flush_state", 64'(dbg_state), 64'd0);
    check("flush_stall_after", 64'(bus.stall), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check("flush_hi", 64'(bus.hi), 64'hFFFFFFF8);
    check("flush_lo", 64'(bus.lo), 64'h55);
`endif

    // reset in the middle of a DIV, with a direct write that must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    repeat (3) @(negedge clk);
    bus.whilo = 2'b11; bus.wdata = 32'hDEAD;
    @(negedge clk);
    bus.whilo = 2'b00;
    repeat (6) @(negedge clk);
    #1;
    check("middiv_state", 64'(dbg_state), 64'd2);
    check("middiv_hi_hold", 64'(bus.hi), 64'hFFFFFFF8);
    check("middiv_lo_hold", 64'(bus.lo), 64'h55);
    resetn = 1'b0; bus.start = 1'b0;
    #1;
    check("mrst_state", 64'(dbg_state), 64'd0);
    check("mrst_stall", 64'(bus.stall), 64'd0);
    check("mrst_hi", 64'(bus.hi), 64'd0);
    check("mrst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("divu_9_3", 3'b011, 32'd9, 32'd3, 32'h0, 32'h3, 33);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Execute-stage multiply/divide unit with the architectural HI/LO registers.
- Sits directly downstream of the ID/EX pipeline register:
  - consumes the EX-stage operands (GPR[rs], GPR[rt]), the mult/div opcode and the HI/LO write enables;
  - supplies HI/LO read data to EX.
- Multi-cycle: asserts a stall to freeze IF/ID/EX while an operation runs.

Parameters:
- MUL_CYCLES, 2, cycles spent in MUL state (legal 1..4).
- DIV_ITER, 32, restoring-division iterations; fixed at 32 for 32-bit operands.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  EX holds a mult/div instruction this cycle.
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU; other codes are no-ops.
- src_a  input  32  GPR[rs] (multiplicand/dividend).
- src_b  input  32  GPR[rt] (multiplier/divisor).
- whilo  input  2  direct write enables: bit1 = HI (MTHI), bit0 = LO (MTLO).
- wdata  input  32  data for MTHI/MTLO.
- stall  output  1  freeze the upstream pipeline; combinational.
- busy  output  1  state is MUL or DIV; registered.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE;
  - hi = lo = 0, busy = 0, stall = 0;
  - counters and operand latches cleared;
  - any partial result is discarded.
- States: IDLE, MUL, DIV, DONE.
- issue = start & (op is 000..011) & state==IDLE.
- IDLE:
  - On issue, latch src_a/src_b/op and go to MUL (op 00x) or DIV (op 01x).
  - Counter loads MUL_CYCLES-1 (MUL) or DIV_ITER-1 (DIV).
  - whilo writes apply here only, on the same edge, to HI and/or LO from wdata.
  - If issue and whilo fall in the same cycle, the direct write lands first; the op result overwrites it later.
- MUL: decrement the counter each cycle. At count 0:
  - write {hi,lo} = 64-bit product (signed for MULT, unsigned for MULTU);
  - go to DONE.
- DIV: one restoring iteration per cycle on operand magnitudes. At the last iteration:
  - write lo = quotient, hi = remainder;
  - go to DONE.
  - Signed fixup: quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
- DONE: lasts one cycle. stall = 0, start and whilo are ignored, hi/lo already show the new result. Next state is IDLE.
  - Purpose: the stalled instruction advances on this edge without re-issuing.
- stall = issue | (state==MUL) | (state==DIV).
  - Stall cycles per op: MULT/MULTU = 1+MUL_CYCLES; DIV/DIVU = 1+DIV_ITER (33).
- hi/lo hold their old values throughout MUL/DIV.
- start or whilo seen in MUL/DIV is ignored; upstream is frozen, so it is re-presented.
- Divide by zero (src_b==0): lo = 32'hFFFFFFFF, hi = src_a. Latency is unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0.
- No-op op codes with start=1: no state change and no stall. whilo is still honoured.

Optional Feature:
- Macro: MULDIV_FLUSH_EN.
- Defined:
  - adds input port flush (1 bit);
  - flush=1 forces state to IDLE on the next edge from any state;
  - hi/lo are not updated by the aborted operation;
  - issue and whilo in the same cycle are suppressed;
  - stall = 0 while flush=1;
  - used for exception/branch-cancel of the EX instruction.
- Undefined: no flush port. An issued operation always runs to completion.

Test Plan:
- MULT src_a=0xFFFFFFFE, src_b=3, MUL_CYCLES=2:
  - stall high 3 cycles, then DONE;
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA;
  - one-cycle DONE, no re-issue while start held.
- MULTU 0xFFFFFFFF x 2: hi=0x00000001, lo=0xFFFFFFFE.
- DIV -7/2: stall high exactly 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7: lo=0x0000000E, hi=0x00000002.
- DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU 5/0: lo=0xFFFFFFFF, hi=5.
- MTHI 0x1234 with an idle unit: hi=0x1234 next edge, stall never asserts.
- Same-cycle MTLO 0xAA plus MULT 2x3: lo=0xAA after 1 edge, then lo=6, hi=0.
- resetn pulsed low mid-DIV (iteration 10):
  - immediately state IDLE, stall=0, hi=lo=0;
  - a new DIVU 9/3 afterwards gives lo=3, hi=0.
- (MULDIV_FLUSH_EN) flush at DIV iteration 5:
  - next cycle IDLE, stall=0;
  - hi/lo retain their pre-issue values.
